jellyvl_etherneco_synctimer_slave: RTL and testbench
====================================================

# jellyvl_etherneco_synctimer_slave

Ring-node counterpart of the EtherNeco synctimer master. It parses the master's sync command as it passes through the node and either loads or nudges the node's local timer through an external `jellyvl_synctimer_timer`. It also measures the node's downstream round-trip time and writes it into the node's slot of the returning response packet. It sits between the node's packet parsers (command and response directions) and the local timer instance.

## Interface
Parameters:
- TIMER_WIDTH, 64, local timer width (≤64)
- MAX_NODES, 2, offset/round-trip slots per packet

Ports:
- reset  in  1  synchronous, active-high
- clk  in  1  clock
- current_time  in  TIMER_WIDTH  local timer value
- set_time  out  TIMER_WIDTH  timer load value
- set_valid  out  1  one-cycle load strobe
- adjust_sign  out  1  1 = retard local timer, 0 = advance
- adjust_valid  out  1  adjust request
- adjust_ready  in  1  timer accepts adjust
- cmd_rx_start  in  1  command packet start
- cmd_rx_end  in  1  command packet end
- cmd_rx_error  in  1  command packet error
- cmd_rx_length  in  16  payload bytes minus one
- cmd_rx_node  in  8  this node's hop index
- cmd_payload_pos  in  16  payload byte index
- cmd_payload_data  in  8  payload byte
- cmd_payload_valid  in  1  payload byte strobe
- res_rx_start  in  1  response packet start
- res_rx_end  in  1  response packet end
- res_rx_error  in  1  response packet error
- res_payload_pos  in  16  payload byte index
- res_payload_valid  in  1  payload byte strobe
- res_replace_data  out  8  substitute byte
- res_replace_valid  out  1  substitute strobe

## Operation
- Command payload layout, little-endian:
  - pos 0: cmd; bit0 = correct, bit1 = override.
  - pos 1..8: master time.
  - pos 9+4i..12+4i: offset for node i (32-bit, unsigned).
- At `cmd_rx_start`:
  - latch `arrive = current_time` and `node = cmd_rx_node`;
  - clear `cmd_ok`.
- While `cmd_payload_valid`: capture the cmd byte, the time bytes, and the offset bytes of the slot `node` only.
- At `cmd_rx_end`, the packet is valid iff all of:
  - `!cmd_rx_error`;
  - `cmd_rx_length == 8+4*MAX_NODES`;
  - `node < MAX_NODES`.
  - If valid, set `cmd_ok = 1`. Otherwise drop the packet and clear `cmd_ok`.
- Arithmetic is modulo 2^TIMER_WIDTH. The master time is truncated to TIMER_WIDTH. The offset is zero-extended.
- Override (bit1 = 1, takes priority over correct):
  - `set_time = rx_time + offset + (current_time@end - arrive)`.
  - Latency is not otherwise compensated; the master calibration absorbs it.
- Correct (bit1 = 0, bit0 = 1):
  - `diff = rx_time + offset - arrive`, signed.
  - diff > 0: adjust with `adjust_sign = 0`.
  - diff < 0: adjust with `adjust_sign = 1`.
  - diff == 0: no request.
- Neither bit set: no timer action. `cmd_ok` is still set.
- Round trip:
  - At `res_rx_start` with `cmd_ok`, latch `rtt = (current_time - arrive)[31:0]` and set `rtt_ok`.
  - At `res_rx_start` without `cmd_ok`, clear `rtt_ok`.
- Replace path (combinational):
  - `res_replace_valid = res_payload_valid && rtt_ok && res_payload_pos == 9+4*node+k`, for k = 0..3.
  - `res_replace_data = rtt` byte k; 0 otherwise.
- `res_rx_end` or `res_rx_error` clears `rtt_ok` and `cmd_ok`. One response consumes one command.
- Adjust handshake:
  - `adjust_valid` holds until `adjust_valid && adjust_ready`.
  - A new request while one is pending overwrites `adjust_sign`; `adjust_valid` stays high.
- A `cmd_rx_start` mid-packet restarts capture and discards partial data.

## Timing
- Reset values:
  - `set_valid = 0`, `set_time = 0`;
  - `adjust_valid = 0`, `adjust_sign = 0`;
  - `cmd_ok = rtt_ok = 0`, so `res_replace_valid = 0`.
  - Reset mid-packet abandons the packet, and any pending adjust is dropped.
- `cmd_rx_end` sampled at cycle E:
  - `set_valid` is high for exactly cycle E+1, with `set_time` stable in E+1.
  - `adjust_valid` rises at E+1.
- `set_time` holds its last value after the strobe.
- `rtt` is valid from the cycle after `res_rx_start`. Payload bytes must not coincide with `res_rx_start`.
- The replace outputs have zero latency from `res_payload_*`.
- `cmd_rx_end` and `cmd_rx_start` in the same cycle: finish the old packet with the data captured so far, then start the new one.

## Test plan
- Override: MAX_NODES = 2, node 1, cmd = 0x02, time = 0x10000, pos 13..16 = 00 01 00 00, arrive = 0x500, end at 0x520 -> set_valid for 1 cycle at E+1, set_time = 0x10120, adjust_valid stays 0.
- Correct: cmd = 0x01, time = 0x1000, offset = 0x10, arrive = 0x1000 -> adjust_valid = 1, adjust_sign = 0; held 5 cycles with ready = 0, drops the cycle after ready = 1. Repeat with arrive = 0x1020 -> adjust_sign = 1.
- Round trip: valid command at local 0x500, res_rx_start at 0x5A0, node 1 -> replace valid exactly at pos 13..16 with data A0, 00, 00, 00; all other positions 0.
- Error or bad length: cmd_rx_error at end, or cmd_rx_length = 15 -> no set/adjust, response not replaced.
- Node out of range: node = 2 -> no timer action, no replace; the next valid packet for node 0 works normally.
- Reset mid-command: assert reset at payload pos 5 -> all outputs at reset values; the next full packet is processed correctly.

Source files
------------

// File: rtl/jellyvl_etherneco_synctimer_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : jellyvl_etherneco_synctimer_slave_if
//  Description : Bundle of timer, command-parser and response-parser signals
//                seen by the EtherNeco synctimer ring-node slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface jellyvl_etherneco_synctimer_slave_if #(
    parameter int TIMER_WIDTH = 64
);
    // local timer side
    logic [TIMER_WIDTH-1:0] current_time;
    logic [TIMER_WIDTH-1:0] set_time;
    logic                   set_valid;
    logic                   adjust_sign;
    logic                   adjust_valid;
    logic                   adjust_ready;

    // command direction parser
    logic                   cmd_rx_start;
    logic                   cmd_rx_end;
    logic                   cmd_rx_error;
    logic [15:0]            cmd_rx_length;
    logic [7:0]             cmd_rx_node;
    logic [15:0]            cmd_payload_pos;
    logic [7:0]             cmd_payload_data;
    logic                   cmd_payload_valid;

    // response direction parser / replacer
    logic                   res_rx_start;
    logic                   res_rx_end;
    logic                   res_rx_error;
    logic [15:0]            res_payload_pos;
    logic                   res_payload_valid;
    logic [7:0]             res_replace_data;
    logic                   res_replace_valid;

    modport slave (
        input  current_time,
        output set_time,
        output set_valid,
        output adjust_sign,
        output adjust_valid,
        input  adjust_ready,
        input  cmd_rx_start,
        input  cmd_rx_end,
        input  cmd_rx_error,
        input  cmd_rx_length,
        input  cmd_rx_node,
        input  cmd_payload_pos,
        input  cmd_payload_data,
        input  cmd_payload_valid,
        input  res_rx_start,
        input  res_rx_end,
        input  res_rx_error,
        input  res_payload_pos,
        input  res_payload_valid,
        output res_replace_data,
        output res_replace_valid
    );

    modport master (
        output current_time,
        input  set_time,
        input  set_valid,
        input  adjust_sign,
        input  adjust_valid,
        output adjust_ready,
        output cmd_rx_start,
        output cmd_rx_end,
        output cmd_rx_error,
        output cmd_rx_length,
        output cmd_rx_node,
        output cmd_payload_pos,
        output cmd_payload_data,
        output cmd_payload_valid,
        output res_rx_start,
        output res_rx_end,
        output res_rx_error,
        output res_payload_pos,
        output res_payload_valid,
        input  res_replace_data,
        input  res_replace_valid
    );
endinterface
`default_nettype wire

// File: rtl/jellyvl_etherneco_synctimer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : jellyvl_etherneco_synctimer_slave
//  Description : Ring-node synctimer slave. Parses the master's sync command,
//                loads or nudges the local timer, and writes this node's
//                round-trip time into its slot of the returning response.
//  Revision    : 1.0  initial release
// ============================================================================
module jellyvl_etherneco_synctimer_slave #(
    parameter int TIMER_WIDTH = 64,
    parameter int MAX_NODES   = 2
) (
    input wire logic                           reset,
    input wire logic                           clk,
    jellyvl_etherneco_synctimer_slave_if.slave bus
);

    localparam logic [15:0] c_cmd_length = 16'(8 + 4 * MAX_NODES);
    localparam logic [8:0]  c_max_nodes  = 9'(MAX_NODES);

    logic [TIMER_WIDTH-1:0] r_arrive;
    logic [7:0]             r_node;
    logic [1:0]             r_cmd;
    logic [63:0]            r_time;
    logic [31:0]            r_offset;
    logic                   r_cmd_ok;
    logic                   r_rtt_ok;
    logic [31:0]            r_rtt;

    logic [7:0]             w_cap_node;
    logic [15:0]            w_cap_base;
    logic [15:0]            w_cap_rel;
    logic [2:0]             w_time_idx;
    logic [15:0]            w_res_base;
    logic [15:0]            w_res_rel;
    logic [TIMER_WIDTH-1:0] w_target;
    logic [TIMER_WIDTH-1:0] w_elapsed;
    logic [TIMER_WIDTH-1:0] w_set;
    logic [TIMER_WIDTH-1:0] w_diff;
    logic                   w_cmd_good;

    // A byte arriving together with cmd_rx_start belongs to the new packet.
    assign w_cap_node = bus.cmd_rx_start ? bus.cmd_rx_node : r_node;
    assign w_cap_base = 16'd9 + {6'd0, w_cap_node, 2'b00};
    assign w_cap_rel  = bus.cmd_payload_pos - w_cap_base;
    assign w_time_idx = bus.cmd_payload_pos[2:0] - 3'd1;

    assign w_target   = TIMER_WIDTH'(r_time) + TIMER_WIDTH'(r_offset);
    assign w_elapsed  = bus.current_time - r_arrive;
    assign w_set      = w_target + w_elapsed;
    assign w_diff     = w_target - r_arrive;

    assign w_cmd_good = !bus.cmd_rx_error
                     && (bus.cmd_rx_length == c_cmd_length)
                     && ({1'b0, r_node} < c_max_nodes);

    assign w_res_base = 16'd9 + {6'd0, r_node, 2'b00};
    assign w_res_rel  = bus.res_payload_pos - w_res_base;

    // Capture arrival time, hop index and the command fields for our slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arrive <= '0;
            r_node   <= '0;
            r_cmd    <= '0;
            r_time   <= '0;
            r_offset <= '0;
        end else begin
            if (bus.cmd_rx_start) begin
                r_arrive <= bus.current_time;
                r_node   <= bus.cmd_rx_node;
                r_cmd    <= '0;
                r_time   <= '0;
                r_offset <= '0;
            end
            if (bus.cmd_payload_valid) begin
                if (bus.cmd_payload_pos == 16'd0) begin
                    r_cmd <= bus.cmd_payload_data[1:0];
                end else if (bus.cmd_payload_pos <= 16'd8) begin
                    r_time[{w_time_idx, 3'b000} +: 8] <= bus.cmd_payload_data;
                end else if (bus.cmd_payload_pos >= w_cap_base && w_cap_rel < 16'd4) begin
                    r_offset[{w_cap_rel[1:0], 3'b000} +: 8] <= bus.cmd_payload_data;
                end
            end
        end
    end

    // Issue the timer load strobe or adjust request when a good command ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.set_time     <= '0;
            bus.set_valid    <= 1'b0;
            bus.adjust_valid <= 1'b0;
            bus.adjust_sign  <= 1'b0;
        end else begin
            bus.set_valid <= 1'b0;
            if (bus.adjust_valid && bus.adjust_ready) begin
                bus.adjust_valid <= 1'b0;
            end
            if (bus.cmd_rx_end && w_cmd_good) begin
                if (r_cmd[1]) begin
                    bus.set_time  <= w_set;
                    bus.set_valid <= 1'b1;
                end else if (r_cmd[0] && (w_diff != '0)) begin
                    // a newer request replaces a pending one's direction
                    bus.adjust_valid <= 1'b1;
                    bus.adjust_sign  <= w_diff[TIMER_WIDTH-1];
                end
            end
        end
    end

    // Track command validity and latch the round trip when the response starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_ok <= 1'b0;
            r_rtt_ok <= 1'b0;
            r_rtt    <= '0;
        end else begin
            if (bus.cmd_rx_end) begin
                r_cmd_ok <= w_cmd_good;
            end
            if (bus.cmd_rx_start) begin
                r_cmd_ok <= 1'b0;
            end
            if (bus.res_rx_start) begin
                if (r_cmd_ok) begin
                    r_rtt    <= 32'(w_elapsed);
                    r_rtt_ok <= 1'b1;
                end else begin
                    r_rtt_ok <= 1'b0;
                end
            end
            // one response consumes one command
            if (bus.res_rx_end || bus.res_rx_error) begin
                r_rtt_ok <= 1'b0;
                r_cmd_ok <= 1'b0;
            end
        end
    end

    // Substitute our four round-trip bytes into this node's response slot.
    always_comb begin
        bus.res_replace_valid = 1'b0;
        bus.res_replace_data  = 8'h00;
        if (bus.res_payload_valid && r_rtt_ok
                && bus.res_payload_pos >= w_res_base && w_res_rel < 16'd4) begin
            bus.res_replace_valid = 1'b1;
            bus.res_replace_data  = r_rtt[{w_res_rel[1:0], 3'b000} +: 8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jellyvl_etherneco_synctimer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jellyvl_etherneco_synctimer_slave
//  Description : Self-checking bench for the synctimer ring-node slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jellyvl_etherneco_synctimer_slave;

    localparam int TW = 64;
    localparam int MN = 2;

    typedef struct {
        int          node;
        logic [15:0] len;
        bit          err;
        logic [7:0]  cmd;
        logic [63:0] t;
        logic [31:0] off;
        logic [63:0] arr;
        logic [63:0] endt;
        logic [31:0] dres;
        bit          esv;
        logic [63:0] est;
        bit          eav;
        bit          eas;
        bit          eok;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jellyvl_etherneco_synctimer_slave_if #(.TIMER_WIDTH(TW)) bus ();

    jellyvl_etherneco_synctimer_slave #(
        .TIMER_WIDTH (TW),
        .MAX_NODES   (MN)
    ) u_dut (
        .reset (reset),
        .clk   (clk),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_set = '0;
    logic [7:0]  pl [0:31];
    vec_t        tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.adjust_ready      = 1'b0;
        bus.cmd_rx_start      = 1'b0;
        bus.cmd_rx_end        = 1'b0;
        bus.cmd_rx_error      = 1'b0;
        bus.cmd_rx_length     = 16'd0;
        bus.cmd_rx_node       = 8'd0;
        bus.cmd_payload_pos   = 16'd0;
        bus.cmd_payload_data  = 8'd0;
        bus.cmd_payload_valid = 1'b0;
        bus.res_rx_start      = 1'b0;
        bus.res_rx_end        = 1'b0;
        bus.res_rx_error      = 1'b0;
        bus.res_payload_pos   = 16'd0;
        bus.res_payload_valid = 1'b0;
    endtask

    // Payload image: cmd, master time LE, then offset slots (others random).
    task automatic build_payload(input logic [7:0] cmd, input logic [63:0] t,
                                 input int node, input logic [31:0] off);
        pl[0] = cmd;
        for (int i = 0; i < 8; i++) pl[1+i] = t[8*i +: 8];
        for (int i = 9; i < 32; i++) pl[i] = 8'($urandom);
        if (node < MN) begin
            for (int k = 0; k < 4; k++) pl[9+4*node+k] = off[8*k +: 8];
        end
    endtask

    // Sends a command packet; returns positioned in cycle E+1.
    task automatic send_cmd(input int node, input logic [15:0] len, input bit err,
                            input logic [63:0] arrive, input logic [63:0] end_t);
        bus.cmd_rx_length = len;
        bus.cmd_rx_node   = 8'(node);
        bus.cmd_rx_start  = 1'b1;
        bus.current_time  = arrive;
        tick();
        bus.cmd_rx_start = 1'b0;
        for (int p = 0; p <= int'(len); p++) begin
            bus.cmd_payload_valid = 1'b1;
            bus.cmd_payload_pos   = 16'(p);
            bus.cmd_payload_data  = pl[p];
            bus.current_time      = arrive + 64'(p) + 64'd1;
            tick();
        end
        bus.cmd_payload_valid = 1'b0;
        bus.cmd_rx_end        = 1'b1;
        bus.cmd_rx_error      = err;
        bus.current_time      = end_t;
        tick();
        bus.cmd_rx_end   = 1'b0;
        bus.cmd_rx_error = 1'b0;
    endtask

    // Runs a response packet and sweeps payload positions 0..20.
    task automatic res_phase(input logic [63:0] res_t, input bit ok, input int node,
                             input logic [63:0] arrive, input string nm);
        logic [63:0] d;
        logic [31:0] rtt;
        logic        ev;
        logic [7:0]  ed;
        d   = res_t - arrive;
        rtt = d[31:0];
        bus.res_rx_start = 1'b1;
        bus.current_time = res_t;
        tick();
        bus.res_rx_start = 1'b0;
        for (int p = 0; p <= 20; p++) begin
            bus.res_payload_valid = 1'b1;
            bus.res_payload_pos   = 16'(p);
            #1;
            ev = 1'b0;
            ed = 8'h00;
            if (ok && p >= 9 + 4*node && p < 13 + 4*node) begin
                ev = 1'b1;
                ed = rtt[8*(p-9-4*node) +: 8];
            end
            check($sformatf("%s.replace_valid@%0d", nm, p), 64'(bus.res_replace_valid), 64'(ev));
            check($sformatf("%s.replace_data@%0d", nm, p), 64'(bus.res_replace_data), 64'(ed));
            tick();
        end
        bus.res_payload_valid = 1'b0;
        bus.res_rx_end        = 1'b1;
        tick();
        bus.res_rx_end = 1'b0;
    endtask

    // Reference model: expected behaviour straight from the packet rules.
    function automatic vec_t model(input vec_t v);
        logic [63:0] diff;
        bit          ok;
        ok    = !v.err && (v.len == 16'(8 + 4*MN)) && (v.node < MN);
        diff  = v.t + 64'(v.off) - v.arr;
        v.eok = ok;
        v.esv = ok && v.cmd[1];
        v.est = v.t + 64'(v.off) + (v.endt - v.arr);
        v.eav = ok && !v.cmd[1] && v.cmd[0] && (diff != 64'd0);
        v.eas = $signed(diff) < 0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        build_payload(v.cmd, v.t, v.node, v.off);
        send_cmd(v.node, v.len, v.err, v.arr, v.endt);
        check({nm, ".set_valid"}, 64'(bus.set_valid), 64'(v.esv));
        check({nm, ".set_time"}, bus.set_time, v.esv ? v.est : last_set);
        if (v.esv) last_set = v.est;
        check({nm, ".adjust_valid"}, 64'(bus.adjust_valid), 64'(v.eav));
        if (v.eav) check({nm, ".adjust_sign"}, 64'(bus.adjust_sign), 64'(v.eas));
        tick();
        check({nm, ".set_valid_drop"}, 64'(bus.set_valid), 64'd0);
        check({nm, ".set_time_hold"}, bus.set_time, last_set);
        check({nm, ".adjust_hold"}, 64'(bus.adjust_valid), 64'(v.eav));
        bus.adjust_ready = 1'b1;
        tick();
        bus.adjust_ready = 1'b0;
        check({nm, ".adjust_done"}, 64'(bus.adjust_valid), 64'd0);
        res_phase(v.arr + 64'(v.dres), v.eok, v.node, v.arr, nm);
    endtask

    initial begin
        vec_t v;

        //          node len     err   cmd    time                   off        arrive   end      dres            esv   est        eav   eas   eok
        tbl[0]  = '{1, 16'd16, 1'b0, 8'h02, 64'h10000,             32'h100,   64'h500, 64'h520, 32'hA0,        1'b1, 64'h10120, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{0, 16'd16, 1'b0, 8'h01, 64'h1000,              32'h10,    64'h1000,64'h1010,32'hA0,        1'b0, 64'h0,     1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1, 16'd16, 1'b0, 8'h01, 64'h1000,              32'h10,    64'h1020,64'h1030,32'h123456A0,  1'b0, 64'h0,     1'b1, 1'b1, 1'b1};
        tbl[3]  = '{0, 16'd16, 1'b0, 8'h01, 64'h1000,              32'h20,    64'h1020,64'h1030,32'hA0,        1'b0, 64'h0,     1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1, 16'd16, 1'b1, 8'h02, 64'h10000,             32'h100,   64'h500, 64'h520, 32'hA0,        1'b0, 64'h0,     1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1, 16'd15, 1'b0, 8'h02, 64'h10000,             32'h100,   64'h500, 64'h520, 32'hA0,        1'b0, 64'h0,     1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2, 16'd16, 1'b0, 8'h02, 64'h10000,             32'h100,   64'h500, 64'h520, 32'hA0,        1'b0, 64'h0,     1'b0, 1'b0, 1'b0};
        tbl[7]  = '{0, 16'd16, 1'b0, 8'h02, 64'h2000,              32'h5,     64'h100, 64'h103, 32'h55,        1'b1, 64'h2008,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1, 16'd16, 1'b0, 8'h00, 64'h5000,              32'h7,     64'h100, 64'h200, 32'hA0,        1'b0, 64'h0,     1'b0, 1'b0, 1'b1};
        tbl[9]  = '{0, 16'd16, 1'b0, 8'h03, 64'h40,                32'h1,     64'h10,  64'h12,  32'hA0,        1'b1, 64'h43,    1'b0, 1'b0, 1'b1};
        tbl[10] = '{1, 16'd16, 1'b0, 8'h01, 64'h0,                 32'h0,     64'h1,   64'h5,   32'hA0,        1'b0, 64'h0,     1'b1, 1'b1, 1'b1};
        tbl[11] = '{0, 16'd16, 1'b0, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF,32'h2,    64'h0,   64'h0,   32'hA0,        1'b1, 64'h1,     1'b0, 1'b0, 1'b1};

        idle_inputs();
        bus.current_time = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        bus.res_payload_valid = 1'b1;
        bus.res_payload_pos   = 16'd13;
        #1;
        check("reset.set_valid", 64'(bus.set_valid), 64'd0);
        check("reset.set_time", bus.set_time, 64'd0);
        check("reset.adjust_valid", 64'(bus.adjust_valid), 64'd0);
        check("reset.adjust_sign", 64'(bus.adjust_sign), 64'd0);
        check("reset.replace_valid", 64'(bus.res_replace_valid), 64'd0);
        check("reset.replace_data", 64'(bus.res_replace_data), 64'd0);
        bus.res_payload_valid = 1'b0;
        tick();

        // directed table
        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // adjust held without ready, then overwritten by an opposite request
        build_payload(8'h01, 64'h1000, 0, 32'h10);
        send_cmd(0, 16'd16, 1'b0, 64'h1000, 64'h1010);
        check("hold.adjust_valid", 64'(bus.adjust_valid), 64'd1);
        check("hold.adjust_sign", 64'(bus.adjust_sign), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold.cycle%0d", c), 64'(bus.adjust_valid), 64'd1);
        end
        build_payload(8'h01, 64'h1000, 0, 32'h10);
        send_cmd(0, 16'd16, 1'b0, 64'h1020, 64'h1030);
        check("overwrite.adjust_valid", 64'(bus.adjust_valid), 64'd1);
        check("overwrite.adjust_sign", 64'(bus.adjust_sign), 64'd1);
        bus.adjust_ready = 1'b1;
        tick();
        bus.adjust_ready = 1'b0;
        check("overwrite.adjust_drop", 64'(bus.adjust_valid), 64'd0);

        // restart mid-packet: partial override packet is discarded
        build_payload(8'h02, 64'hDEAD_BEEF, 0, 32'h77);
        bus.cmd_rx_length = 16'd16;
        bus.cmd_rx_node   = 8'd0;
        bus.cmd_rx_start  = 1'b1;
        tick();
        bus.cmd_rx_start = 1'b0;
        for (int p = 0; p < 9; p++) begin
            bus.cmd_payload_valid = 1'b1;
            bus.cmd_payload_pos   = 16'(p);
            bus.cmd_payload_data  = pl[p];
            tick();
        end
        bus.cmd_payload_valid = 1'b0;
        run_vec(tbl[7], "restart");

        // reset mid-command with an adjust pending
        build_payload(8'h01, 64'h1000, 0, 32'h10);
        send_cmd(0, 16'd16, 1'b0, 64'h1020, 64'h1030);
        check("prereset.adjust_valid", 64'(bus.adjust_valid), 64'd1);
        build_payload(8'h02, 64'h10000, 1, 32'h100);
        bus.cmd_rx_length = 16'd16;
        bus.cmd_rx_node   = 8'd1;
        bus.cmd_rx_start  = 1'b1;
        tick();
        bus.cmd_rx_start = 1'b0;
        for (int p = 0; p <= 5; p++) begin
            bus.cmd_payload_valid = 1'b1;
            bus.cmd_payload_pos   = 16'(p);
            bus.cmd_payload_data  = pl[p];
            tick();
        end
        bus.cmd_payload_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_set = '0;
        check("midreset.set_valid", 64'(bus.set_valid), 64'd0);
        check("midreset.set_time", bus.set_time, 64'd0);
        check("midreset.adjust_valid", 64'(bus.adjust_valid), 64'd0);
        check("midreset.adjust_sign", 64'(bus.adjust_sign), 64'd0);
        res_phase(64'h5A0, 1'b0, 1, 64'h500, "midreset");
        run_vec(tbl[0], "postreset");

        // randomized packets against the reference model
        for (int i = 0; i < 40; i++) begin
            v.node = ($urandom_range(0, 3) == 0) ? 2 : int'($urandom_range(0, 1));
            v.len  = ($urandom_range(0, 4) == 0) ? 16'd15 : 16'd16;
            v.err  = ($urandom_range(0, 9) == 0);
            v.cmd  = 8'($urandom_range(0, 3));
            v.t    = {$urandom, $urandom};
            v.off  = $urandom;
            v.arr  = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) v.arr = v.t + 64'(v.off);
            v.endt = v.arr + 64'($urandom_range(0, 1000));
            v.dres = $urandom;
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
